axi_lite_master_arbiter: RTL and testbench
==========================================

// Module: axi_lite_master_arbiter
// PURPOSE
// Shares one AXI4-Lite slave register port (axi4_lite, gpio/status regs) between NUM_REQ
// on-chip requesters using simple request/response command interfaces. Grants one command
// at a time round-robin, drives the AW/W/B or AR/R channels as an AXI4-Lite master, and
// routes the response (resp code, read data) back to the granted requester.
// PARAMETERS
// NUM_REQ     2   number of requesters, 2..8
// ADDR_WIDTH  8   AXI byte address width
// DATA_WIDTH  32  AXI data width; strobe width is DATA_WIDTH/8
// PORTS
// clk            in   1                    clock; all logic rises on posedge
// rst            in   1                    asynchronous, active-high reset
// req_valid      in   NUM_REQ              per-requester command valid
// req_we         in   NUM_REQ              1=write, 0=read
// req_addr       in   NUM_REQ*ADDR_WIDTH   packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
// req_wdata      in   NUM_REQ*DATA_WIDTH   packed write data
// req_wstrb      in   NUM_REQ*DATA_WIDTH/8 packed write strobes
// req_ready      out  NUM_REQ              one-hot 1-cycle pulse: command accepted (grant)
// rsp_valid      out  NUM_REQ              one-hot 1-cycle pulse: command complete
// rsp_resp       out  2                    BRESP/RRESP of completed command
// rsp_rdata      out  DATA_WIDTH           RDATA for reads; 0 for writes
// busy           out  1                    high in any state other than IDLE
// m_axi_aw*/w*/b*/ar*/r*  AXI4-Lite master channels: awaddr, awvalid, awready, wdata, wstrb,
//                wvalid, wready, bresp, bvalid, bready, araddr, arvalid, arready, rdata,
//                rresp, rvalid, rready (standard widths and directions)
// BEHAVIOUR
// Reset: state=IDLE, rr pointer=NUM_REQ-1 (req0 wins first); all outputs 0 (valids, bready,
//   rready, req_ready, rsp_valid, rsp_resp, rsp_rdata, busy, addresses/data).
// States: IDLE -> WR (AW+W) -> WR_B -> RESP -> IDLE ; IDLE -> RD_A -> RD_R -> RESP -> IDLE.
// IDLE: if any req_valid, select the first set bit searching upward from pointer+1 (mod
//   NUM_REQ); req_ready[g]=1 that cycle (combinational from registered state + req_valid);
//   latch we/addr/wdata/wstrb and g; pointer<=g. No grant outside IDLE.
// Requester must hold req_valid and fields stable until req_ready; dropping valid earlier
//   is allowed (no grant occurs).
// WR: awvalid and wvalid both rise the cycle after grant. Each drops independently on its own
//   handshake (awvalid&awready / wvalid&wready). Go to WR_B when both done (same cycle allowed).
// WR_B: bready=1; on bvalid latch bresp, rdata<=0, go RESP.
// RD_A: arvalid=1 until arready. RD_R: rready=1; on rvalid latch rresp and rdata, go RESP.
// RESP: rsp_valid[g]=1 for exactly one cycle with rsp_resp/rsp_rdata valid; no backpressure.
//   rsp_resp/rsp_rdata hold until next RESP.
// Minimum latency, slave always ready: grant T, AW/W T+1, bvalid T+2 earliest, rsp_valid T+3.
// Addr/data/strb outputs stable while their valid is high. Never more than one outstanding txn.
// SLVERR/DECERR forwarded unchanged; no retry. No timeout: a hung slave stalls the block.
// Reset mid-transaction: all AXI valids/readies drop immediately; no rsp_valid is generated;
//   the in-flight command is lost and the slave must be reset together with this block.
// TESTING
// 1 req0 write 0x00<=0xDEADBEEF, strb 0xF; slave ready -> single AW/W beat, rsp_valid[0], resp 00;
//   then req1 read 0x00 -> rsp_valid[1], rdata 0xDEADBEEF, gpio_o follows bit0.
// 2 req0,req1 both held valid for 4 commands after reset -> grant order 0,1,0,1; never two
//   req_ready bits in one cycle; rsp_valid order matches grants.
// 3 slave holds awready low 3 cycles, wready immediate -> wvalid high 1 cycle, awvalid 4 cycles
//   with awaddr stable; bready not asserted before AW handshake completes.
// 4 read unmapped 0xFC with slave RRESP=2'b10 -> rsp_resp=2'b10 on correct requester only.
// 5 rst pulse while in WR_B -> bready/valids 0 at once, no rsp_valid; next simultaneous req -> req0.
// 6 req1 asserted while busy with req0 -> req1 gets no req_ready until the cycle after RESP.

Source files
------------

// File: rtl/axi_lite_master_arbiter.sv
// axi_lite_master_arbiter
// Round-robin arbiter that lets NUM_REQ simple command requesters share one
// AXI4-Lite master port. One transaction is in flight at a time; the response
// code and read data are returned to the requester that was granted.

module axi_lite_master_arbiter #(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  // requester command side
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ-1:0]                req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]     req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_wdata,
  input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0] req_wstrb,
  output logic [NUM_REQ-1:0]                req_ready,
  // requester response side
  output logic [NUM_REQ-1:0]                rsp_valid,
  output logic [1:0]                        rsp_resp,
  output logic [DATA_WIDTH-1:0]             rsp_rdata,
  output logic                              busy,
  // AXI4-Lite write address
  output logic [ADDR_WIDTH-1:0]             m_axi_awaddr,
  output logic                              m_axi_awvalid,
  input  logic                              m_axi_awready,
  // AXI4-Lite write data
  output logic [DATA_WIDTH-1:0]             m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]           m_axi_wstrb,
  output logic                              m_axi_wvalid,
  input  logic                              m_axi_wready,
  // AXI4-Lite write response
  input  logic [1:0]                        m_axi_bresp,
  input  logic                              m_axi_bvalid,
  output logic                              m_axi_bready,
  // AXI4-Lite read address
  output logic [ADDR_WIDTH-1:0]             m_axi_araddr,
  output logic                              m_axi_arvalid,
  input  logic                              m_axi_arready,
  // AXI4-Lite read data
  input  logic [DATA_WIDTH-1:0]             m_axi_rdata,
  input  logic [1:0]                        m_axi_rresp,
  input  logic                              m_axi_rvalid,
  output logic                              m_axi_rready
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned IDX_WIDTH  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR   = 3'd1,
    S_WR_B = 3'd2,
    S_RD_A = 3'd3,
    S_RD_R = 3'd4,
    S_RESP = 3'd5
  } state_t;

  // state and registered outputs
  state_t                  r_state;
  logic [IDX_WIDTH-1:0]    r_ptr;
  logic [IDX_WIDTH-1:0]    r_gnt;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [STRB_WIDTH-1:0]   r_wstrb;
  logic                    r_awvalid;
  logic                    r_wvalid;
  logic                    r_arvalid;
  logic                    r_bready;
  logic                    r_rready;
  logic [NUM_REQ-1:0]      r_rsp_valid;
  logic [1:0]              r_rsp_resp;
  logic [DATA_WIDTH-1:0]   r_rsp_rdata;
  logic                    r_busy;

  // combinational next values
  state_t                  w_state_nxt;
  logic                    w_any;
  logic [IDX_WIDTH-1:0]    w_sel;
  logic                    w_ld_cmd;
  logic                    w_ld_b;
  logic                    w_ld_r;
  logic                    w_awvalid_nxt;
  logic                    w_wvalid_nxt;
  logic                    w_arvalid_nxt;
  logic                    w_bready_nxt;
  logic                    w_rready_nxt;
  logic [NUM_REQ-1:0]      w_rsp_valid_nxt;

  // Round-robin pick: first valid requester above the pointer, wrapping.
  // Scanning downward and overwriting leaves the nearest candidate in w_sel.
  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    for (int unsigned k = NUM_REQ; k >= 1; k--) begin
      if (req_valid[IDX_WIDTH'((32'(r_ptr) + k) % NUM_REQ)]) begin
        w_any = 1'b1;
        w_sel = IDX_WIDTH'((32'(r_ptr) + k) % NUM_REQ);
      end
    end
  end

  // Next-state, grant pulse and next values of the channel controls.
  always_comb begin
    w_state_nxt     = r_state;
    w_ld_cmd        = 1'b0;
    w_ld_b          = 1'b0;
    w_ld_r          = 1'b0;
    w_awvalid_nxt   = r_awvalid;
    w_wvalid_nxt    = r_wvalid;
    w_arvalid_nxt   = r_arvalid;
    w_bready_nxt    = 1'b0;
    w_rready_nxt    = 1'b0;
    w_rsp_valid_nxt = '0;
    req_ready       = '0;

    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          req_ready[w_sel] = 1'b1;
          w_ld_cmd         = 1'b1;
          if (req_we[w_sel]) begin
            w_state_nxt   = S_WR;
            w_awvalid_nxt = 1'b1;
            w_wvalid_nxt  = 1'b1;
          end else begin
            w_state_nxt   = S_RD_A;
            w_arvalid_nxt = 1'b1;
          end
        end
      end

      // AW and W complete independently; leave once both have handshaken
      S_WR: begin
        w_awvalid_nxt = r_awvalid & ~m_axi_awready;
        w_wvalid_nxt  = r_wvalid & ~m_axi_wready;
        if (!w_awvalid_nxt && !w_wvalid_nxt) begin
          w_state_nxt  = S_WR_B;
          w_bready_nxt = 1'b1;
        end
      end

      S_WR_B: begin
        w_bready_nxt = 1'b1;
        if (m_axi_bvalid) begin
          w_ld_b                 = 1'b1;
          w_bready_nxt           = 1'b0;
          w_rsp_valid_nxt[r_gnt] = 1'b1;
          w_state_nxt            = S_RESP;
        end
      end

      S_RD_A: begin
        w_arvalid_nxt = r_arvalid & ~m_axi_arready;
        if (!w_arvalid_nxt) begin
          w_state_nxt  = S_RD_R;
          w_rready_nxt = 1'b1;
        end
      end

      S_RD_R: begin
        w_rready_nxt = 1'b1;
        if (m_axi_rvalid) begin
          w_ld_r                 = 1'b1;
          w_rready_nxt           = 1'b0;
          w_rsp_valid_nxt[r_gnt] = 1'b1;
          w_state_nxt            = S_RESP;
        end
      end

      S_RESP: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Channel handshake controls and busy flag; reset drops them immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_bready    <= 1'b0;
      r_rready    <= 1'b0;
      r_rsp_valid <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_awvalid   <= w_awvalid_nxt;
      r_wvalid    <= w_wvalid_nxt;
      r_arvalid   <= w_arvalid_nxt;
      r_bready    <= w_bready_nxt;
      r_rready    <= w_rready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
    end
  end

  // Command capture at grant; fields stay stable for the whole transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr   <= IDX_WIDTH'(NUM_REQ - 1);
      r_gnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
    end else if (w_ld_cmd) begin
      r_ptr   <= w_sel;
      r_gnt   <= w_sel;
      r_addr  <= req_addr[32'(w_sel) * ADDR_WIDTH +: ADDR_WIDTH];
      r_wdata <= req_wdata[32'(w_sel) * DATA_WIDTH +: DATA_WIDTH];
      r_wstrb <= req_wstrb[32'(w_sel) * STRB_WIDTH +: STRB_WIDTH];
    end
  end

  // Response capture; holds until the next completed transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_resp  <= 2'b00;
      r_rsp_rdata <= '0;
    end else if (w_ld_b) begin
      r_rsp_resp  <= m_axi_bresp;
      r_rsp_rdata <= '0;
    end else if (w_ld_r) begin
      r_rsp_resp  <= m_axi_rresp;
      r_rsp_rdata <= m_axi_rdata;
    end
  end

  assign rsp_valid     = r_rsp_valid;
  assign rsp_resp      = r_rsp_resp;
  assign rsp_rdata     = r_rsp_rdata;
  assign busy          = r_busy;
  assign m_axi_awaddr  = r_addr;
  assign m_axi_awvalid = r_awvalid;
  assign m_axi_wdata   = r_wdata;
  assign m_axi_wstrb   = r_wstrb;
  assign m_axi_wvalid  = r_wvalid;
  assign m_axi_bready  = r_bready;
  assign m_axi_araddr  = r_addr;
  assign m_axi_arvalid = r_arvalid;
  assign m_axi_rready  = r_rready;

endmodule

// File: tb/tb_axi_lite_master_arbiter.sv
// Bench for axi_lite_master_arbiter: a register-file AXI4-Lite slave model,
// a table of single commands, and hand-written multi-cycle sequences.

module tb_axi_lite_master_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_we;
  logic [15:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wstrb;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_resp;
  logic [31:0] rsp_rdata;
  logic        busy;
  logic [7:0]  m_axi_awaddr;
  logic        m_axi_awvalid;
  logic        m_axi_awready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wvalid;
  logic        m_axi_wready;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid;
  logic        m_axi_bready;
  logic [7:0]  m_axi_araddr;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rvalid;
  logic        m_axi_rready;

  axi_lite_master_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_resp(rsp_resp), .rsp_rdata(rsp_rdata), .busy(busy),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // clock and cycle counter
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- slave model (register file, 0xFC unmapped) ----------------
  logic [31:0] mem [64];
  logic        gpio_o;
  int          aw_delay = 0;
  logic        b_stall  = 1'b0;
  logic        s_awv, s_wv, s_bready, s_arv, s_rready;
  logic [7:0]  s_awaddr, s_araddr, sl_awaddr;
  logic [31:0] s_wdata, sl_wdata;
  logic [3:0]  s_wstrb, sl_wstrb;
  logic        aw_got, w_got;
  int          aw_cnt;

  assign gpio_o = mem[0][0];

  // Slave reacts on the falling edge: detects the handshakes of the last
  // rising edge from its snapshot, then drives its ready/valid outputs.
  always @(negedge clk) begin
    if (rst) begin
      m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_arready = 1'b0;
      m_axi_bvalid  = 1'b0; m_axi_bresp  = 2'b00;
      m_axi_rvalid  = 1'b0; m_axi_rresp  = 2'b00; m_axi_rdata = 32'h0;
      aw_got = 1'b0; w_got = 1'b0; aw_cnt = 0;
      s_awv = 1'b0; s_wv = 1'b0; s_bready = 1'b0; s_arv = 1'b0; s_rready = 1'b0;
    end else begin
      if (s_awv && m_axi_awready) begin aw_got = 1'b1; sl_awaddr = s_awaddr; end
      if (s_wv && m_axi_wready) begin w_got = 1'b1; sl_wdata = s_wdata; sl_wstrb = s_wstrb; end
      if (m_axi_bvalid && s_bready) m_axi_bvalid = 1'b0;
      if (m_axi_rvalid && s_rready) m_axi_rvalid = 1'b0;
      if (s_arv && m_axi_arready) begin
        m_axi_rvalid = 1'b1;
        if (s_araddr == 8'hFC) begin
          m_axi_rresp = 2'b10; m_axi_rdata = 32'hBAD0BAD0;
        end else begin
          m_axi_rresp = 2'b00; m_axi_rdata = mem[s_araddr[7:2]];
        end
      end
      if (aw_got && w_got && !b_stall) begin
        if (sl_awaddr == 8'hFC) begin
          m_axi_bresp = 2'b10;
        end else begin
          m_axi_bresp = 2'b00;
          for (int b = 0; b < 4; b++)
            if (sl_wstrb[b]) mem[sl_awaddr[7:2]][8*b +: 8] = sl_wdata[8*b +: 8];
        end
        m_axi_bvalid = 1'b1;
        aw_got = 1'b0; w_got = 1'b0;
      end
      if (m_axi_awvalid) begin
        m_axi_awready = (aw_cnt >= aw_delay);
        aw_cnt++;
      end else begin
        m_axi_awready = 1'b0;
        aw_cnt = 0;
      end
      m_axi_wready  = m_axi_wvalid;
      m_axi_arready = m_axi_arvalid;
      s_awv = m_axi_awvalid; s_wv = m_axi_wvalid; s_bready = m_axi_bready;
      s_arv = m_axi_arvalid; s_rready = m_axi_rready;
      s_awaddr = m_axi_awaddr; s_wdata = m_axi_wdata; s_wstrb = m_axi_wstrb;
      s_araddr = m_axi_araddr;
    end
  end

  // ---------------- protocol monitor ----------------
  logic mon_en = 1'b0;
  int   mon_aw = 0, mon_w = 0, mon_addr_chg = 0, mon_early_b = 0, mon_rsp = 0;

  // One-hot grant/response checks plus AW/W/B counters for the stall sequence.
  always @(negedge clk) begin
    if (!rst) begin
      if (req_ready != 2'b00) chk("ready_onehot", 64'($countones(req_ready)), 64'd1);
      if (rsp_valid != 2'b00) begin
        chk("rsp_onehot", 64'($countones(rsp_valid)), 64'd1);
        mon_rsp++;
      end
      if (mon_en) begin
        if (m_axi_awvalid) mon_aw++;
        if (m_axi_wvalid) mon_w++;
        if (m_axi_awvalid && m_axi_awaddr != 8'h08) mon_addr_chg++;
        if (m_axi_bready && m_axi_awvalid) mon_early_b++;
      end
    end
  end

  // ---------------- requester helpers ----------------
  task automatic issue(input int i, input logic we, input logic [7:0] a,
                       input logic [31:0] d, input logic [3:0] s, output int gc);
    logic got;
    got = 1'b0;
    gc  = 0;
    @(posedge clk); #1;
    req_we[i] = we;
    req_addr[i*8 +: 8]   = a;
    req_wdata[i*32 +: 32] = d;
    req_wstrb[i*4 +: 4]  = s;
    req_valid[i] = 1'b1;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (req_ready[i]) begin got = 1'b1; gc = cyc; end
    end
    chk("grant_seen", 64'(got), 64'd1);
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_rsp(output logic [1:0] v, output logic [1:0] r,
                          output logic [31:0] d, output int c);
    logic ok;
    ok = 1'b0; v = 2'b00; r = 2'b00; d = 32'h0; c = 0;
    for (int n = 0; n < 60 && !ok; n++) begin
      @(negedge clk);
      if (rsp_valid != 2'b00) begin
        ok = 1'b1; v = rsp_valid; r = rsp_resp; d = rsp_rdata; c = cyc;
      end
    end
    chk("rsp_seen", 64'(ok), 64'd1);
  endtask

  function automatic int oh2i(input logic [1:0] v);
    return v[1] ? 1 : 0;
  endfunction

  typedef struct {
    int          rq;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [9];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int          gc, rc, g0, g1, r0, ng, nr, rsp0;
    logic [1:0]  rv, rr;
    logic [31:0] rd, rd1;
    logic        got;
    int          gl [8];
    int          rl [8];

    vecs[0] = '{0, 1'b1, 8'h00, 32'hDEADBEEF, 4'hF, 2'b00, 32'h00000000};
    vecs[1] = '{1, 1'b0, 8'h00, 32'h0,        4'h0, 2'b00, 32'hDEADBEEF};
    vecs[2] = '{1, 1'b1, 8'h04, 32'h12345678, 4'h3, 2'b00, 32'h00000000};
    vecs[3] = '{0, 1'b0, 8'h04, 32'h0,        4'h0, 2'b00, 32'h00005678};
    vecs[4] = '{0, 1'b1, 8'h04, 32'hAABBCCDD, 4'hC, 2'b00, 32'h00000000};
    vecs[5] = '{1, 1'b0, 8'h04, 32'h0,        4'h0, 2'b00, 32'hAABB5678};
    vecs[6] = '{0, 1'b0, 8'hFC, 32'h0,        4'h0, 2'b10, 32'hBAD0BAD0};
    vecs[7] = '{1, 1'b1, 8'hFC, 32'h55555555, 4'hF, 2'b10, 32'h00000000};
    vecs[8] = '{1, 1'b0, 8'hFC, 32'h0,        4'h0, 2'b10, 32'hBAD0BAD0};

    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    rst = 1'b1;
    req_valid = 2'b00; req_we = 2'b00; req_addr = '0; req_wdata = '0; req_wstrb = '0;

    // reset state
    repeat (3) @(negedge clk);
    chk("reset_handshakes",
        64'({req_ready, rsp_valid, busy, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid,
             m_axi_bready, m_axi_rready}), 64'd0);
    chk("reset_rsp", 64'({rsp_resp, rsp_rdata}), 64'd0);
    chk("reset_addr_data", 64'({m_axi_awaddr, m_axi_araddr, m_axi_wdata, m_axi_wstrb}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // table of single commands, slave always ready
    for (int i = 0; i < 9; i++) begin
      issue(vecs[i].rq, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, gc);
      wait_rsp(rv, rr, rd, rc);
      chk($sformatf("v%0d_rsp_valid", i), 64'(rv), 64'd1 << vecs[i].rq);
      chk($sformatf("v%0d_rsp_resp", i), 64'(rr), 64'(vecs[i].exp_resp));
      chk($sformatf("v%0d_rsp_rdata", i), 64'(rd), 64'(vecs[i].exp_rdata));
      chk($sformatf("v%0d_latency", i), 64'(rc - gc), 64'd3);
      @(negedge clk);
      chk($sformatf("v%0d_pulse_idle", i), 64'({rsp_valid, busy}), 64'd0);
      chk($sformatf("v%0d_resp_hold", i), 64'({rsp_resp, rsp_rdata}),
          64'({vecs[i].exp_resp, vecs[i].exp_rdata}));
    end
    chk("gpio_o", 64'(gpio_o), 64'd1);

    // both requesters held valid: alternate grants starting with req0
    @(posedge clk); #1;
    req_we    = 2'b01;
    req_addr  = {8'h20, 8'h20};
    req_wdata = {32'h0, 32'hCAFE0001};
    req_wstrb = {4'h0, 4'hF};
    req_valid = 2'b11;
    ng = 0; nr = 0; rd1 = 32'h0;
    for (int n = 0; n < 100 && nr < 4; n++) begin
      @(negedge clk);
      if (rsp_valid != 2'b00 && nr < 8) begin
        rl[nr] = oh2i(rsp_valid);
        if (rsp_valid[1]) rd1 = rsp_rdata;
        nr++;
      end
      if (req_ready != 2'b00 && ng < 8) begin
        gl[ng] = oh2i(req_ready);
        ng++;
        if (ng == 4) begin @(posedge clk); #1; req_valid = 2'b00; end
      end
    end
    req_valid = 2'b00;
    chk("rr_grant_count", 64'(ng), 64'd4);
    chk("rr_rsp_count", 64'(nr), 64'd4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rr_grant%0d", k), 64'(gl[k]), 64'(k % 2));
      chk($sformatf("rr_rsp%0d", k), 64'(rl[k]), 64'(k % 2));
    end
    chk("rr_read_data", 64'(rd1), 64'h0000_0000_CAFE_0001);

    // awready held off 3 cycles, wready immediate
    @(posedge clk); #1;
    aw_delay = 3;
    mon_aw = 0; mon_w = 0; mon_addr_chg = 0; mon_early_b = 0;
    mon_en = 1'b1;
    issue(1, 1'b1, 8'h08, 32'h0F0F0F0F, 4'hF, gc);
    wait_rsp(rv, rr, rd, rc);
    mon_en = 1'b0;
    aw_delay = 0;
    chk("stall_rsp", 64'({rv, rr}), 64'({2'b10, 2'b00}));
    chk("stall_awvalid_cycles", 64'(mon_aw), 64'd4);
    chk("stall_wvalid_cycles", 64'(mon_w), 64'd1);
    chk("stall_awaddr_stable", 64'(mon_addr_chg), 64'd0);
    chk("stall_no_early_bready", 64'(mon_early_b), 64'd0);
    chk("stall_mem", 64'(mem[2]), 64'h0F0F0F0F);

    // reset while waiting for B
    b_stall = 1'b1;
    issue(0, 1'b1, 8'h10, 32'h11111111, 4'hF, gc);
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (m_axi_bready) got = 1'b1;
    end
    chk("rst_reached_wr_b", 64'(got), 64'd1);
    rsp0 = mon_rsp;
    #1 rst = 1'b1;
    #1;
    chk("rst_immediate",
        64'({m_axi_bready, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_rready,
             busy, rsp_valid}), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    b_stall = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_no_rsp", 64'(mon_rsp - rsp0), 64'd0);
    chk("rst_mem_untouched", 64'(mem[4]), 64'd0);
    @(posedge clk); #1;
    req_we = 2'b00; req_addr = {8'h00, 8'h00};
    req_valid = 2'b11;
    got = 1'b0; rv = 2'b00;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (req_ready != 2'b00) begin got = 1'b1; rv = req_ready; end
    end
    chk("rst_first_grant", 64'(rv), 64'd1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    wait_rsp(rv, rr, rd, rc);
    chk("rst_after_read", 64'({rv, rr, rd}), 64'({2'b01, 2'b00, 32'hDEADBEEF}));

    // req1 arrives while req0 is in flight
    @(posedge clk); #1;
    req_we = 2'b00; req_addr = {8'h00, 8'h04};
    req_valid = 2'b01;
    got = 1'b0; g0 = 0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (req_ready[0]) begin got = 1'b1; g0 = cyc; end
    end
    chk("busy_grant0", 64'(got), 64'd1);
    @(posedge clk); #1;
    req_valid = 2'b10;
    g1 = -1; r0 = -100; rd1 = 32'h0;
    for (int n = 0; n < 40 && g1 < 0; n++) begin
      @(negedge clk);
      if (rsp_valid[0]) begin r0 = cyc; rd1 = rsp_rdata; end
      if (req_ready[1]) g1 = cyc;
    end
    chk("busy_req0_data", 64'(rd1), 64'h0000_0000_AABB_5678);
    chk("busy_req0_latency", 64'(r0 - g0), 64'd3);
    chk("busy_req1_after_resp", 64'(g1 - r0), 64'd1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    wait_rsp(rv, rr, rd, rc);
    chk("busy_req1_rsp", 64'({rv, rd}), 64'({2'b10, 32'hDEADBEEF}));

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
